// File: rtl/program_memory_pkg.sv
// Shared types and constants for the instruction program memory and its byte loader.
package program_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } pm_state_e;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/program_memory_byte_assembler.sv
// Packs a stream of loader bytes into words, first byte landing in the MSB.
// o_Word/o_WordValid are combinational so the word can be written on the edge of its last byte.
module byte_assembler #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_Clear,
    input  logic                  i_ByteValid,
    input  logic [BYTE_WIDTH-1:0] i_Byte,
    output logic [WORD_WIDTH-1:0] o_Word,
    output logic                  o_WordValid
);
    localparam int NB   = WORD_WIDTH / BYTE_WIDTH;
    localparam int CNTW = (NB > 1) ? $clog2(NB) : 1;

    logic [WORD_WIDTH-1:0] shift_q;
    logic [CNTW-1:0]       cnt_q;
    logic                  last_byte;

    assign last_byte   = (cnt_q == CNTW'(NB - 1));
    assign o_Word      = (shift_q << BYTE_WIDTH) | WORD_WIDTH'(i_Byte);
    assign o_WordValid = i_ByteValid && last_byte;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_Clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_ByteValid) begin
            shift_q <= o_Word;
            cnt_q   <= last_byte ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/program_memory.sv
// Instruction memory filled by a byte-serial loader, then read by PC with 1-cycle latency.
// state | meaning
// IDLE  | after reset, nothing loaded, reads return NOP
// LOAD  | bytes assembled into words and written sequentially
// READY | program loaded (HALT seen or memory full), fetch allowed
module program_memory
    import program_memory_pkg::*;
#(
    parameter int                    MEM_DEPTH   = 256,
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    ADDR_LENGTH = 32,
    parameter int                    BYTE_WIDTH  = 8,
    parameter logic [WORD_WIDTH-1:0] HALT_WORD   = WORD_WIDTH'(DEFAULT_HALT_WORD)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_LoadStart,
    input  logic                           i_ByteValid,
    input  logic [BYTE_WIDTH-1:0]          i_Byte,
    input  logic [ADDR_LENGTH-1:0]         i_Addr,
    input  logic                           i_Enable,
    input  logic                           i_Flush,
    output logic [WORD_WIDTH-1:0]          o_Data,
    output logic                           o_Ready,
    output logic                           o_Loading,
    output logic [$clog2(MEM_DEPTH):0]     o_WordCount,
    output logic                           o_Full
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;

    pm_state_e             state;
    logic [AW-1:0]         wr_ptr;
    logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];
    logic [WORD_WIDTH-1:0] rd_raw;
    logic [WORD_WIDTH-1:0] asm_word;
    logic                  asm_valid;
    logic                  byte_en;
    logic                  data_valid;
    logic [AW-1:0]         rd_index;
    logic                  addr_oob;
    logic                  read_ok;
    logic                  unused_addr_lsbs;

    // A byte arriving with a restart is dropped; the assembler is cleared instead.
    assign byte_en = (state == ST_LOAD) && i_ByteValid && !i_LoadStart && !i_reset;

    byte_assembler #(
        .WORD_WIDTH (WORD_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_byte_assembler (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_Clear     (i_LoadStart),
        .i_ByteValid (byte_en),
        .i_Byte      (i_Byte),
        .o_Word      (asm_word),
        .o_WordValid (asm_valid)
    );

    assign rd_index         = i_Addr[AW+1:2];
    assign addr_oob         = |(i_Addr >> (AW + 2));
    assign unused_addr_lsbs = ^i_Addr[1:0];
    assign read_ok          = (state == ST_READY) && !i_LoadStart && !addr_oob
                              && ({1'b0, rd_index} < o_WordCount);

    // Storage kept reset-free with plain write/read ports so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (asn_we_unused_guard(asm_valid)) mem[wr_ptr] <= asm_word;
        if (i_Enable) rd_raw <= mem[rd_index];
    end

    function automatic logic asn_we_unused_guard(input logic we);
        return we;
    endfunction

    // Stale RAM contents are masked by data_valid rather than cleared.
    assign o_Data = data_valid ? rd_raw : WORD_WIDTH'(NOP_WORD);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            o_WordCount <= '0;
            o_Ready     <= 1'b0;
            o_Loading   <= 1'b0;
            o_Full      <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            if (i_Flush)       data_valid <= 1'b0;
            else if (i_Enable) data_valid <= read_ok;

            if (i_LoadStart) begin
                state       <= ST_LOAD;
                wr_ptr      <= '0;
                o_WordCount <= '0;
                o_Ready     <= 1'b0;
                o_Loading   <= 1'b1;
                o_Full      <= 1'b0;
            end else if (state == ST_LOAD && asm_valid) begin
                wr_ptr      <= wr_ptr + 1'b1;
                o_WordCount <= o_WordCount + 1'b1;
                if (asm_word == HALT_WORD) begin
                    state     <= ST_READY;
                    o_Ready   <= 1'b1;
                    o_Loading <= 1'b0;
                end else if (o_WordCount == CW'(MEM_DEPTH - 1)) begin
                    state     <= ST_READY;
                    o_Ready   <= 1'b1;
                    o_Loading <= 1'b0;
                    o_Full    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: default-depth instance plus a 4-word instance sharing stimulus.
module tb_program_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic [31:0] addr = 32'h0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;

    logic [31:0] data, data4;
    logic        ready, ready4, loading, loading4, full, full4;
    logic [8:0]  word_count;
    logic [2:0]  word_count4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    program_memory dut (
        .i_clk(clk), .i_reset(reset), .i_LoadStart(load_start), .i_ByteValid(byte_valid),
        .i_Byte(byte_in), .i_Addr(addr), .i_Enable(enable), .i_Flush(flush),
        .o_Data(data), .o_Ready(ready), .o_Loading(loading), .o_WordCount(word_count), .o_Full(full)
    );

    program_memory #(.MEM_DEPTH(4)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_LoadStart(load_start), .i_ByteValid(byte_valid),
        .i_Byte(byte_in), .i_Addr(addr), .i_Enable(enable), .i_Flush(flush),
        .o_Data(data4), .o_Ready(ready4), .o_Loading(loading4), .o_WordCount(word_count4), .o_Full(full4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic read(input logic [31:0] a);
        addr   = a;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_data", data, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_loading", loading, 0);
        check_eq("rst_count", word_count, 0);
        check_eq("rst_full", full, 0);

        read(32'h0);
        check_eq("idle_read_data", data, 0);
        check_eq("idle_read_ready", ready, 0);

        // Basic load: one instruction followed by HALT
        start_load();
        check_eq("load_flag", loading, 1);
        send_word(32'h2008_0005);
        check_eq("count_after_w0", word_count, 1);
        send_word(32'hFFFF_FFFF);
        check_eq("count_after_halt", word_count, 2);
        check_eq("ready_after_halt", ready, 1);
        check_eq("loading_after_halt", loading, 0);
        check_eq("full_after_halt", full, 0);
        read(32'h0);
        check_eq("read_a0", data, 32'h2008_0005);
        read(32'h4);
        check_eq("read_a4_halt", data, 32'hFFFF_FFFF);
        read(32'h8);
        check_eq("read_a8_beyond_count", data, 0);
        read(32'h2);
        check_eq("read_a2_lsbs_ignored", data, 32'h2008_0005);
        read(32'h400);
        check_eq("read_oob_high_bit", data, 0);

        // Stall holds, flush forces NOP and beats enable
        read(32'h0);
        addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_hold", data, 32'h2008_0005);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_no_enable", data, 0);
        read(32'h0);
        check_eq("reread_a0", data, 32'h2008_0005);
        flush  = 1'b1;
        enable = 1'b1;
        tick();
        flush  = 1'b0;
        enable = 1'b0;
        check_eq("flush_over_enable", data, 0);

        // Read coinciding with a new load start returns NOP
        read(32'h0);
        addr       = 32'h0;
        enable     = 1'b1;
        load_start = 1'b1;
        tick();
        enable     = 1'b0;
        load_start = 1'b0;
        check_eq("loadstart_read_nop", data, 0);
        check_eq("loadstart_ready", ready, 0);
        check_eq("loadstart_loading", loading, 1);
        check_eq("loadstart_count", word_count, 0);

        // Restart mid-word: stale bytes and the byte sent with the restart are dropped
        send_byte(8'hAA);
        send_byte(8'hBB);
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hCC;
        tick();
        load_start = 1'b0;
        byte_valid = 1'b0;
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        check_eq("restart_count", word_count, 2);
        check_eq("restart_ready", ready, 1);
        read(32'h0);
        check_eq("restart_word0", data, 32'h1234_5678);

        // Fill the 4-word instance without HALT, then extra bytes
        start_load();
        send_word(32'h0102_0304);
        send_word(32'h0506_0708);
        send_word(32'h090A_0B0C);
        send_word(32'h0D0E_0F10);
        check_eq("d4_full", full4, 1);
        check_eq("d4_count", word_count4, 4);
        check_eq("d4_ready", ready4, 1);
        check_eq("d4_loading", loading4, 0);
        send_word(32'h1112_1314);
        check_eq("d4_count_after_extra", word_count4, 4);
        check_eq("d4_full_after_extra", full4, 1);
        check_eq("main_count_5", word_count, 5);
        check_eq("main_not_full", full, 0);
        check_eq("main_still_loading", loading, 1);
        read(32'hC);
        check_eq("d4_read_a12", data4, 32'h0D0E_0F10);
        check_eq("main_read_in_load_nop", data, 0);
        read(32'h0);
        check_eq("d4_read_a0", data4, 32'h0102_0304);
        read(32'h10);
        check_eq("d4_read_oob", data4, 0);

        // Reset mid-load, then a clean reload
        start_load();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst_loading", loading, 0);
        check_eq("midrst_ready", ready, 0);
        check_eq("midrst_count", word_count, 0);
        check_eq("midrst_data", data, 0);
        check_eq("midrst_full4", full4, 0);
        check_eq("midrst_count4", word_count4, 0);
        start_load();
        send_word(32'hDEAD_BEEF);
        send_word(32'hFFFF_FFFF);
        check_eq("reload_count", word_count, 2);
        read(32'h0);
        check_eq("reload_word0", data, 32'hDEAD_BEEF);
        read(32'h4);
        check_eq("reload_word1", data, 32'hFFFF_FFFF);
        read(32'h8);
        check_eq("stale_word_masked", data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 The block SHALL have exactly one clock, i_clk, and one reset, i_reset; i_reset is synchronous and active-high.
REQ-002 Parameters (name, default, meaning) SHALL be:
- MEM_DEPTH, 256, words stored.
- WORD_WIDTH, 32, instruction width; a multiple of BYTE_WIDTH.
- ADDR_LENGTH, 32, PC byte-address width.
- BYTE_WIDTH, 8, loader byte width.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- i_clk, in, 1, clock.
- i_reset, in, 1, synchronous active-high reset.
- i_LoadStart, in, 1, start or restart a program load.
- i_ByteValid, in, 1, i_Byte is valid this cycle.
- i_Byte, in, BYTE_WIDTH, loader byte.
- i_Addr, in, ADDR_LENGTH, PC byte address.
- i_Enable, in, 1, read enable; low means stall.
- i_Flush, in, 1, force NOP on the next output.
- o_Data, out, WORD_WIDTH, fetched instruction.
- o_Ready, out, 1, program loaded and fetch allowed.
- o_Loading, out, 1, FSM in LOAD.
- o_WordCount, out, clog2(MEM_DEPTH)+1, words written.
- o_Full, out, 1, memory filled without HALT_WORD.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD and READY.
REQ-005 IDLE->LOAD and READY->LOAD SHALL occur on i_LoadStart; entering LOAD SHALL clear the word pointer, byte counter, o_WordCount, o_Ready and o_Full.
REQ-006 i_LoadStart asserted while in LOAD SHALL restart the load exactly as REQ-005; a byte valid in the same cycle SHALL be discarded.
REQ-007 In LOAD, each i_ByteValid byte SHALL be shifted into an assembler, first byte into the MSB (big-endian); bytes outside LOAD SHALL be ignored.
REQ-008 On the (WORD_WIDTH/BYTE_WIDTH)-th byte, the assembled word SHALL be written at the pointer in the same clock edge, and the pointer and o_WordCount SHALL both increment.
REQ-009 A written word equal to HALT_WORD SHALL be stored and counted, and the FSM SHALL move to READY on that edge.
REQ-010 When o_WordCount reaches MEM_DEPTH without HALT_WORD, the FSM SHALL move to READY with o_Full=1; no further writes SHALL occur.
REQ-011 o_Ready SHALL be 1 exactly in READY; o_Loading SHALL be 1 exactly in LOAD.
REQ-012 Word index SHALL be i_Addr[clog2(MEM_DEPTH)+1:2]; i_Addr[1:0] SHALL be ignored; any set bit above the index range SHALL count as out of range.
REQ-013 The read SHALL be synchronous with 1-cycle latency: in READY with i_Enable=1, o_Data SHALL take mem[index] on the next edge.
REQ-014 o_Data SHALL be NOP (all zeros) if the index is out of range, if the index is >= o_WordCount, or if the state is not READY.
REQ-015 i_Enable=0 SHALL hold o_Data unchanged.
REQ-016 i_Flush=1 SHALL load NOP into o_Data on the next edge, with priority over i_Enable.
REQ-017 Simultaneous i_LoadStart and a read in READY SHALL give o_Data=NOP on that edge.

Reset
REQ-018 i_reset SHALL set state IDLE, pointer, byte counter and o_WordCount to 0, o_Data to NOP, and o_Ready, o_Loading and o_Full to 0.
REQ-019 i_reset SHALL take priority over all other inputs, including in the middle of a load.
REQ-020 Memory contents SHALL NOT be reset; stale words SHALL be masked by REQ-014.

Structure
REQ-021 Package program_memory_pkg SHALL hold the state enum, the NOP_WORD constant and the default HALT_WORD.
REQ-022 Byte packing SHALL be a sub-module, byte_assembler (shift register plus byte counter, with a word_valid pulse output).
REQ-023 The storage array SHALL be inferable as block RAM: one write port, one synchronous read port.

Verification
REQ-024 Reset, then read i_Addr=0 with i_Enable=1 -> o_Data=0, o_Ready=0.
REQ-025 Load bytes 20,08,00,05 then FF,FF,FF,FF, then read i_Addr=0 and then 4 -> o_Data=32'h20080005, then 32'hFFFFFFFF; o_WordCount=2, o_Ready=1; read i_Addr=8 -> 0.
REQ-026 With MEM_DEPTH=4, load 16 non-halt bytes and then 4 more -> o_Full=1, o_WordCount=4, extra bytes ignored.
REQ-027 In READY: hold i_Enable=0 for 3 cycles -> o_Data held; i_Flush=1 with i_Enable=0 -> o_Data=0 next cycle.
REQ-028 Send 2 bytes, then i_LoadStart, then a full word plus HALT_WORD -> first stored word built only from the post-restart bytes; o_WordCount=2.
REQ-029 Assert i_reset after 3 bytes -> IDLE, all outputs 0; a new load then stores words correctly.
